pipe_chain_ctrl: RTL and testbench
==================================

// Module: pipe_chain_ctrl
// PURPOSE
//  Parametrised N-stage in-order pipeline register chain with per-stage stall (busy), flush and bubble insertion.
//  Generalises the core's hand-written fetch/decode/execute/memory/write context-register update:
//   one valid/ready chain, payload width, depth, flush and perf counting all parametrised.
//  Sits between a producer (fetch) and a consumer (retire). Stage 0 = youngest, stage NSTAGE-1 = oldest.
// PARAMETERS
//  NSTAGE     5      number of pipeline stages (>=2)
//  WIDTH      64     payload (context) width per stage, bits
//  RESET_VAL  '0     payload value held by an invalid (reset/flushed/bubble) stage
//  CNT_W      32     width of stall/bubble performance counters
// PORTS
//  clk          in   1               clock, all state updates on posedge
//  resetn       in   1               synchronous, active-low reset
//  in_valid     in   1               producer has payload for stage 0
//  in_ready     out  1               stage 0 accepts this cycle
//  in_data      in   WIDTH           producer payload
//  busy         in   NSTAGE          busy[i]=1: stage i holds its content (multicycle op)
//  flush_req    in   NSTAGE          flush_req[i]=1: kill stages 0..i at next edge
//  out_valid    out  1               oldest stage presents payload
//  out_ready    in   1               consumer accepts
//  out_data     out  WIDTH           stage NSTAGE-1 payload
//  stage_valid  out  NSTAGE          registered valid of each stage
//  stage_data   out  NSTAGE*WIDTH    registered payload, stage i at [i*WIDTH +: WIDTH]
//  occupancy    out  $clog2(NSTAGE+1) number of valid stages (combinational popcount)
//  cnt_clr      in   1               synchronous clear of both counters
//  stall_cnt    out  CNT_W           cycles with in_valid && !in_ready
//  bubble_cnt   out  CNT_W           cycles with out_ready && !out_valid
// BEHAVIOUR
//  - Reset: all stage_valid=0, stage_data=RESET_VAL, counters=0; hence out_valid=0, occupancy=0, in_ready=1 (if no flush).
//  - Accept chain (combinational, oldest first): acc[N-1] = !v[N-1] || (!busy[N-1] && out_ready);
//    acc[i] = !v[i] || (!busy[i] && acc[i+1]). in_ready = acc[0] && !(|flush_req).
//  - out_valid = v[N-1] && !busy[N-1] && !flush_req[N-1]; transfer when out_valid && out_ready.
//  - Stage i next state (no flush): if acc[i]: load from stage i-1 if v[i-1] && !busy[i-1] (stage 0: in_valid && in_ready),
//    else bubble (v=0, data=RESET_VAL). If !acc[i]: hold.
//  - Latency: one payload per cycle; in->out minimum NSTAGE cycles with no busy/stall.
//  - Flush: k = highest index with flush_req[k]=1; stages 0..k become invalid/RESET_VAL at the edge, regardless of busy.
//    Stage k+1 receives a bubble (never the killed stage k). Stages >k advance normally. Multiple flushes: highest wins.
//  - Flush overrides input: while any flush_req is set, in_ready=0 and nothing enters stage 0.
//  - busy on an invalid stage is ignored (acc=1). busy never drops content; back-pressure ripples to younger stages same cycle.
//  - Counters: saturate at all-ones, no wrap; cnt_clr has priority over increment; reset clears.
//  - Reset mid-operation: all in-flight payloads discarded in one cycle, no out_valid in reset cycle's aftermath.
//  - No combinational path from in_valid to out_valid; out_ready->in_ready path is combinational (documented).
// TESTING
//  - Stream: NSTAGE=5, in_valid=1 data 1,2,3..., out_ready=1 -> out_data 1 at cycle 5, then one per cycle, bubble_cnt=5.
//  - Busy: busy[2]=1 for 3 cycles with full pipe -> stages 0..2 hold, stage 3 gets 3 bubbles, stall_cnt +=3.
//  - Flush: full pipe, flush_req[1] one cycle -> v[0],v[1]=0, v[2] bubble next, stages 3,4 retire normally; in_ready=0 that cycle.
//  - Simultaneous: flush_req=5'b00101 with busy[2]=1 -> stages 0..2 cleared (busy ignored), stage 3 gets bubble.
//  - Back-pressure: out_ready=0 for 10 cycles -> occupancy reaches 5, in_ready=0, no payload lost/duplicated on release.
//  - Counters: force stall_cnt near all-ones (CNT_W=4) -> saturates at 15; cnt_clr with increment same cycle -> 0.

Source files
------------

// File: rtl/pipe_chain_ctrl.sv
// rtl/pipe_chain_ctrl.sv - parametrised in-order pipeline register chain with stall, flush and bubbles
//
// Purpose:
//   NSTAGE-deep valid/ready register chain between a producer (fetch) and a
//   consumer (retire). Stage 0 is the youngest stage and stage NSTAGE-1 is the oldest.
//   Each stage can be held with busy[i] or killed with flush_req.
//   Two saturating performance counters count input stalls and output bubbles.
//
// Ports:
//   clk, resetn             clock; synchronous active-low reset
//   in_valid/in_ready/in_data    producer handshake into stage 0
//   busy[NSTAGE]            per-stage hold request (ignored on an invalid stage)
//   flush_req[NSTAGE]       flush_req[i] kills stages 0..i at the next edge
//   out_valid/out_ready/out_data consumer handshake from stage NSTAGE-1
//   stage_valid, stage_data registered per-stage state, stage i at [i*WIDTH +: WIDTH]
//   occupancy               number of valid stages (combinational popcount)
//   cnt_clr                 synchronous clear of both counters
//   stall_cnt, bubble_cnt   saturating counters: in_valid&&!in_ready, out_ready&&!out_valid
//
// Timing note: out_ready reaches in_ready through the accept chain combinationally.
// There is no combinational path from in_valid to out_valid.

module pipe_chain_ctrl #(
  parameter int                 NSTAGE    = 5,
  parameter int                 WIDTH     = 64,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 32,
  localparam int                OCC_W     = $clog2(NSTAGE + 1)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [NSTAGE-1:0]        busy,
  input  logic [NSTAGE-1:0]        flush_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [NSTAGE-1:0]        stage_valid,
  output logic [NSTAGE*WIDTH-1:0]  stage_data,
  output logic [OCC_W-1:0]         occupancy,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  logic [NSTAGE-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [NSTAGE];
  logic [WIDTH-1:0]  d_d [NSTAGE];
  logic [NSTAGE-1:0] acc;     // stage i can take new content this cycle
  logic [NSTAGE-1:0] kill;    // stage i is covered by some flush at index >= i
  logic [NSTAGE-1:0] src_ok;  // the feeder of stage i offers a live payload
  logic              any_flush;
  logic              stall_inc, bubble_inc;

  // Accept chain is evaluated from the oldest stage toward the youngest.
  // Kill mask: a flush at index k covers every younger stage as well.
  always_comb begin
    acc  = '0;
    kill = '0;
    acc[NSTAGE-1]  = !v_q[NSTAGE-1] || (!busy[NSTAGE-1] && out_ready);
    kill[NSTAGE-1] = flush_req[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      acc[i]  = !v_q[i] || (!busy[i] && acc[i+1]);
      kill[i] = flush_req[i] || kill[i+1];
    end
  end

  assign any_flush = kill[0];
  assign in_ready  = acc[0] && !any_flush;
  assign out_valid = v_q[NSTAGE-1] && !busy[NSTAGE-1] && !flush_req[NSTAGE-1];
  assign out_data  = d_q[NSTAGE-1];

  // A killed stage never feeds its successor.
  // The stage just above the flush boundary therefore takes a bubble.
  always_comb begin
    src_ok    = '0;
    src_ok[0] = in_valid && in_ready;
    for (int i = 1; i < NSTAGE; i++) begin
      src_ok[i] = v_q[i-1] && !busy[i-1] && !kill[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < NSTAGE; i++) begin
      d_d[i] = d_q[i];
    end
    for (int i = 0; i < NSTAGE; i++) begin
      if (kill[i]) begin
        v_d[i] = 1'b0;
        d_d[i] = RESET_VAL;
      end else if (acc[i]) begin
        if (src_ok[i]) begin
          v_d[i] = 1'b1;
          d_d[i] = (i == 0) ? in_data : d_q[(i == 0) ? 0 : i-1];
        end else begin
          v_d[i] = 1'b0;
          d_d[i] = RESET_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v_q <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < NSTAGE; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign stage_valid = v_q;

  for (genvar g = 0; g < NSTAGE; g++) begin : g_pack
    assign stage_data[g*WIDTH +: WIDTH] = d_q[g];
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      occupancy = occupancy + OCC_W'(v_q[i]);
    end
  end

  assign stall_inc  = in_valid && !in_ready;
  assign bubble_inc = out_ready && !out_valid;

  // Counters saturate at all-ones. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!resetn || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bubble_inc && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// tb/tb_pipe_chain_ctrl.sv - scoreboard bench for pipe_chain_ctrl

module tb_pipe_chain_ctrl;

  localparam int NS = 5;
  localparam int W  = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [NS-1:0]   busy;
  logic [NS-1:0]   flush_req;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [NS-1:0]   stage_valid;
  logic [NS*W-1:0] stage_data;
  logic [2:0]      occupancy;
  logic            cnt_clr;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   bubble_cnt;

  pipe_chain_ctrl #(.NSTAGE(NS), .WIDTH(W), .RESET_VAL('0), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .flush_req(flush_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] dropped;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each retired payload with the oldest expected one.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected nothing", out_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("sb_data", 64'(out_data), 64'(mon_exp));
      end
    end
  end

  // One clock. An accepted payload is pushed as expected output.
  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    logic acc_flag;
    @(negedge clk);
    acc_flag = resetn && in_valid && in_ready;
    if (acc_flag) sb.push_back(in_data);
    @(posedge clk);
    #1;
    if (acc_flag) in_data = in_data + 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 30 && occupancy != 0; i++) cyc();
    chk({nm, "_occ"}, 64'(occupancy), 64'd0);
    chk({nm, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = 16'd1; busy = '0;
    flush_req = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_data", 64'(stage_data[W-1:0]), 64'd0);
    resetn = 1'b1;

    // Stream: the first payload reaches the output after 5 edges, with 5 bubble cycles before it.
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (5) cyc();
    chk("stream_out_valid", 64'(out_valid), 64'd1);
    chk("stream_out_data", 64'(out_data), 64'd1);
    chk("stream_bubble", 64'(bubble_cnt), 64'd5);
    chk("stream_full", 64'(stage_valid), 64'h1f);

    // Busy on stage 2 for 3 cycles: stages 0..2 hold and stage 3 takes bubbles.
    busy = 5'b00100;
    repeat (3) cyc();
    chk("busy_valid", 64'(stage_valid), 64'h07);
    chk("busy_stall", 64'(stall_cnt), 64'd3);
    chk("busy_bubble", 64'(bubble_cnt), 64'd6);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    busy = '0; in_valid = 1'b0;
    drain("busy_drain");

    // Flush at stage 1 with a full pipe.
    in_valid = 1'b1;
    repeat (5) cyc();
    flush_req = 5'b00010;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    cyc();
    flush_req = '0; in_valid = 1'b0;
    chk("flush_valid", 64'(stage_valid), 64'h18);
    repeat (2) dropped = sb.pop_back();
    drain("flush_drain");

    // Flush at stages 0 and 2 while stage 2 is busy: the flush wins over busy.
    in_valid = 1'b1;
    repeat (5) cyc();
    flush_req = 5'b00101; busy = 5'b00100;
    cyc();
    flush_req = '0; busy = '0; in_valid = 1'b0;
    chk("simul_valid", 64'(stage_valid), 64'h10);
    repeat (3) dropped = sb.pop_back();
    drain("simul_drain");

    // Back-pressure, then counter saturation and clear-over-increment.
    cnt_clr = 1'b1; out_ready = 1'b0;
    cyc();
    cnt_clr = 1'b0;
    chk("clr_stall", 64'(stall_cnt), 64'd0);
    chk("clr_bubble", 64'(bubble_cnt), 64'd0);
    in_valid = 1'b1;
    repeat (10) cyc();
    chk("bp_occ", 64'(occupancy), 64'd5);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_stall", 64'(stall_cnt), 64'd5);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_bubble", 64'(bubble_cnt), 64'd0);
    repeat (12) cyc();
    chk("sat_stall", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("clr_prio_stall", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    drain("bp_drain");

    // Reset in the middle of operation discards everything in flight.
    in_valid = 1'b1;
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    sb.delete();
    resetn = 1'b1; in_valid = 1'b0;
    chk("mid_rst_valid", 64'(stage_valid), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    cyc();
    chk("mid_rst_out_valid2", 64'(out_valid), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
